// File: rtl/sha3_pkg.sv
// Shared constants, types and helpers for the SHA3-256 absorb front end.
package sha3_pkg;

    localparam int         WIDTH        = 64;
    localparam int         RATE_LANES   = 17;
    localparam int         RATE_BYTES   = 136;
    localparam logic [7:0] DS_BYTE      = 8'h06;
    localparam logic [7:0] PAD_END_BYTE = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        SEND
    } state_t;

    typedef logic [4:0] lane_t;

    typedef logic [0:4][0:4][WIDTH-1:0] state_array_t;

    // Byte counts above a full lane are treated as a full lane.
    function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
        return (n > 4'd8) ? 4'd8 : n;
    endfunction

endpackage

// File: rtl/sha3_absorb_padder_pad_lane.sv
// keccak_pad_lane: returns a lane with one selected byte ORed with a pad byte.
module keccak_pad_lane #(
    parameter int WIDTH = 64,
    parameter int BW    = $clog2(WIDTH / 8)
) (
    input  logic [WIDTH-1:0] lane_in,
    input  logic [BW-1:0]    byte_idx,
    input  logic [7:0]       or_byte,
    output logic [WIDTH-1:0] lane_out
);

    always_comb begin
        lane_out = lane_in;
        for (int i = 0; i < WIDTH / 8; i++) begin
            if (byte_idx == BW'(i)) begin
                lane_out[8*i +: 8] = lane_in[8*i +: 8] | or_byte;
            end
        end
    end

endmodule

// File: rtl/sha3_absorb_padder.sv
// SHA3-256 absorb padder: packs a byte-counted word stream into padded rate blocks.
// Optional macro SHA3_PAD_ERR_EN adds a sticky pad_err output for malformed byte counts.
module sha3_absorb_padder
    import sha3_pkg::*;
#(
    parameter int         WIDTH      = sha3_pkg::WIDTH,
    parameter int         RATE_LANES = sha3_pkg::RATE_LANES,
    parameter logic [7:0] DS_BYTE    = sha3_pkg::DS_BYTE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic [3:0]                       in_bytes,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [0:4][0:4][WIDTH-1:0]       Din,
    output logic                             Din_valid,
    output logic                             Last_block,
    input  logic                             Ready
`ifdef SHA3_PAD_ERR_EN
    ,
    output logic                             pad_err
`endif
);

    localparam int    LANE_BYTES  = WIDTH / 8;
    localparam int    BLOCK_BYTES = RATE_LANES * LANE_BYTES;
    localparam int    PW          = $clog2(BLOCK_BYTES + 1);
    localparam int    BW          = $clog2(LANE_BYTES);
    localparam lane_t LAST_LANE   = lane_t'(RATE_LANES - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] buffer [RATE_LANES];
    lane_t            lane_cnt;
    logic [PW-1:0]    pad_pos;
    logic             extra_pending;
    logic             last_block_r;
    logic             started;

    logic             accept;
    logic [3:0]       bytes_eff;
    logic [WIDTH-1:0] word_mask;
    logic             pad_full;
    lane_t            pad_lane;
    logic [BW-1:0]    pad_byte;
    logic [WIDTH-1:0] ds_lane_in;
    logic [WIDTH-1:0] ds_lane;
    logic [WIDTH-1:0] end_lane_in;
    logic [WIDTH-1:0] end_lane;

    assign accept    = in_valid & in_ready;
    assign bytes_eff = clamp_bytes(in_bytes);
    assign pad_full  = (pad_pos == PW'(BLOCK_BYTES));
    // A full-block pad position has no lane of its own; steer it to lane 0 to keep the read in range.
    assign pad_lane  = pad_full ? '0 : lane_t'(pad_pos[PW-1:BW]);
    assign pad_byte  = pad_pos[BW-1:0];

    always_comb begin
        word_mask = '0;
        for (int i = 0; i < LANE_BYTES; i++) begin
            word_mask[8*i +: 8] = (i < int'(bytes_eff)) ? 8'hff : 8'h00;
        end
    end

    // When the domain byte lands in the last lane, the end marker must stack on top of it.
    assign ds_lane_in  = buffer[pad_lane];
    assign end_lane_in = (pad_lane == LAST_LANE) ? ds_lane : buffer[RATE_LANES-1];

    keccak_pad_lane #(
        .WIDTH    (WIDTH)
    ) u_ds_pad (
        .lane_in  (ds_lane_in),
        .byte_idx (pad_byte),
        .or_byte  (DS_BYTE),
        .lane_out (ds_lane)
    );

    keccak_pad_lane #(
        .WIDTH    (WIDTH)
    ) u_end_pad (
        .lane_in  (end_lane_in),
        .byte_idx (BW'(LANE_BYTES - 1)),
        .or_byte  (PAD_END_BYTE),
        .lane_out (end_lane)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL: begin
                if (accept) begin
                    if (in_last) begin
                        next_state = PAD;
                    end else if (lane_cnt == LAST_LANE) begin
                        next_state = SEND;
                    end
                end
            end
            PAD:     next_state = SEND;
            SEND: begin
                if (Ready) begin
                    next_state = extra_pending ? PAD : FILL;
                end
            end
            default: next_state = FILL;
        endcase
    end

    always_comb begin
        in_ready   = (state == FILL) && started;
        Din_valid  = (state == SEND);
        Last_block = last_block_r;
        Din        = '0;
        for (int k = 0; k < RATE_LANES; k++) begin
            Din[k % 5][k / 5] = buffer[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RATE_LANES; k++) begin
                buffer[k] <= '0;
            end
            lane_cnt      <= '0;
            pad_pos       <= '0;
            extra_pending <= 1'b0;
            last_block_r  <= 1'b0;
            started       <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                FILL: begin
                    if (accept) begin
                        buffer[lane_cnt] <= in_data & word_mask;
                        lane_cnt         <= lane_cnt + lane_t'(1);
                        last_block_r     <= 1'b0;
                        if (in_last) begin
                            pad_pos <= PW'({lane_cnt, {BW{1'b0}}}) + PW'(bytes_eff);
                        end
                    end
                end
                PAD: begin
                    // A message ending on a block boundary ships unpadded, then a pad-only block follows.
                    if (pad_full) begin
                        extra_pending <= 1'b1;
                        last_block_r  <= 1'b0;
                    end else begin
                        buffer[pad_lane]       <= ds_lane;
                        buffer[RATE_LANES-1]   <= end_lane;
                        last_block_r           <= 1'b1;
                    end
                end
                SEND: begin
                    if (Ready) begin
                        for (int k = 0; k < RATE_LANES; k++) begin
                            buffer[k] <= '0;
                        end
                        lane_cnt     <= '0;
                        last_block_r <= 1'b0;
                        if (extra_pending) begin
                            extra_pending <= 1'b0;
                            pad_pos       <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHA3_PAD_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_err <= 1'b0;
        end else if (accept && ((in_bytes > 4'd8) || ((in_bytes != 4'd8) && !in_last))) begin
            pad_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sha3_absorb_padder.sv
// Directed scoreboard bench for sha3_absorb_padder using a byte-level SHA3 padding model.
module tb_sha3_absorb_padder;

    typedef struct packed {
        logic [0:4][0:4][63:0] din;
        logic                  last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [63:0]           in_data;
    logic [3:0]            in_bytes;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [0:4][0:4][63:0] Din;
    logic                  Din_valid;
    logic                  Last_block;
    logic                  Ready;
`ifdef SHA3_PAD_ERR_EN
    logic                  pad_err;
`endif

    exp_t         exp_q[$];
    byte unsigned msg[$];
    int           checks = 0;
    int           fails  = 0;

    sha3_absorb_padder dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_bytes   (in_bytes),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .Din        (Din),
        .Din_valid  (Din_valid),
        .Last_block (Last_block),
        .Ready      (Ready)
`ifdef SHA3_PAD_ERR_EN
        ,
        .pad_err    (pad_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference padding: append domain byte, zero-fill to a block multiple, OR 0x80 into the final byte.
    task automatic buildExpected();
        byte unsigned pad[$];
        exp_t         e;
        int           nblk;
        logic [63:0]  lane;
        pad = msg;
        pad.push_back(8'h06);
        while ((pad.size() % 136) != 0) pad.push_back(8'h00);
        pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
        nblk = pad.size() / 136;
        for (int b = 0; b < nblk; b++) begin
            e.din = '0;
            for (int k = 0; k < 17; k++) begin
                lane = '0;
                for (int j = 0; j < 8; j++) lane[8*j +: 8] = pad[b*136 + 8*k + j];
                e.din[k % 5][k / 5] = lane;
            end
            e.last = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic sendWord(input logic [63:0] data, input logic [3:0] nb, input logic last);
        logic accepted;
        in_data  = data;
        in_bytes = nb;
        in_last  = last;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 50 && !accepted; c++) begin
            if (in_ready === 1'b1) accepted = 1'b1;
            @(negedge clk);
        end
        checkVal("word_accept", 64'(accepted), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic applyStimulus();
        int          len;
        int          nwords;
        int          nb;
        logic [63:0] data;
        buildExpected();
        len    = msg.size();
        nwords = (len == 0) ? 1 : (len + 7) / 8;
        for (int w = 0; w < nwords; w++) begin
            nb = len - 8*w;
            if (nb > 8) nb = 8;
            data = {$urandom, $urandom};
            for (int j = 0; j < nb; j++) data[8*j +: 8] = msg[8*w + j];
            sendWord(data, 4'(nb), w == nwords - 1);
        end
    endtask

    task automatic checkOutput(input int hold);
        logic got;
        exp_t e;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (Din_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        checkVal("din_valid_rise", 64'(got), 64'd1);
        checkVal("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (!got || exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            for (int k = 0; k < 25; k++) begin
                checkVal($sformatf("lane%0d", k), Din[k % 5][k / 5], e.din[k % 5][k / 5]);
            end
            checkVal("last_block", 64'(Last_block), 64'(e.last));
            checkVal("din_valid", 64'(Din_valid), 64'd1);
            checkVal("in_ready_send", 64'(in_ready), 64'd0);
            if (h < hold) @(negedge clk);
        end
        Ready = 1'b1;
        @(negedge clk);
        Ready = 1'b0;
        checkVal("din_valid_after", 64'(Din_valid), 64'd0);
        if (exp_q.size() == 0) checkVal("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    task automatic runMessage(input int hold);
        int n;
        applyStimulus();
        n = exp_q.size();
        for (int i = 0; i < n; i++) checkOutput(hold);
    endtask

    task automatic setAbc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    task automatic setPattern(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'(i) ^ 8'h5a);
    endtask

    initial begin
        int len;
        rst      = 1'b1;
        in_data  = '0;
        in_bytes = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        Ready    = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 25; k++) checkVal($sformatf("rst_lane%0d", k), Din[k % 5][k / 5], 64'd0);
        checkVal("rst_din_valid", 64'(Din_valid), 64'd0);
        checkVal("rst_last_block", 64'(Last_block), 64'd0);
        checkVal("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        checkVal("in_ready_pre_clock", 64'(in_ready), 64'd0);
        @(negedge clk);
        checkVal("in_ready_post_reset", 64'(in_ready), 64'd1);

        $display("[TB] empty message");
        msg.delete();
        runMessage(0);

        $display("[TB] abc message");
        setAbc();
        runMessage(0);

        $display("[TB] 135-byte message");
        setPattern(135);
        runMessage(0);

        $display("[TB] 136-byte message");
        setPattern(136);
        runMessage(0);

        $display("[TB] backpressure");
        setAbc();
        runMessage(25);

        $display("[TB] reset during fill");
        for (int w = 0; w < 9; w++) sendWord({$urandom, $urandom}, 4'd8, 1'b0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 25; k++) checkVal($sformatf("abort_lane%0d", k), Din[k % 5][k / 5], 64'd0);
        checkVal("abort_din_valid", 64'(Din_valid), 64'd0);
        checkVal("abort_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        setAbc();
        runMessage(0);

        $display("[TB] word-boundary and random lengths");
        setPattern(128);
        runMessage(0);
        setPattern(129);
        runMessage(0);
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(0, 136);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            runMessage($urandom_range(0, 3));
        end

`ifdef SHA3_PAD_ERR_EN
        checkVal("pad_err_clean", 64'(pad_err), 64'd0);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
